// File: rtl/ysyx_24110015_bus_pkg.sv
// Shared encodings and default widths for the memory-port arbiter.
package ysyx_24110015_bus_pkg;

    localparam int BUS_AW      = 32;
    localparam int BUS_DW      = 32;
    localparam int BUS_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

endpackage

// File: rtl/ysyx_24110015_timeout_cnt.sv
// Counts cycles while enabled; flags expiry on the TIMEOUT-th counted cycle and on
// any later one. TIMEOUT=0 disables expiry entirely.
module ysyx_24110015_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int TC_INT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CW-1:0] TC = CW'(TC_INT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the cycles already counted, so cnt_q >= TIMEOUT-1 is the TIMEOUT-th one.
    assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q >= TC);

endmodule

// File: rtl/ysyx_24110015_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU and LSU, one transaction
// in flight, with a response timeout that returns an error to the owner.
module ysyx_24110015_mem_arbiter
    import ysyx_24110015_bus_pkg::*;
#(
    parameter int AW      = BUS_AW,
    parameter int DW      = BUS_DW,
    parameter int TIMEOUT = BUS_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [AW-1:0]   ifu_addr,
    output logic            ifu_resp_valid,
    input  logic            ifu_resp_ready,
    output logic [DW-1:0]   ifu_rdata,
    output logic            ifu_err,
    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic [AW-1:0]   lsu_addr,
    input  logic            lsu_wen,
    input  logic [DW-1:0]   lsu_wdata,
    input  logic [DW/8-1:0] lsu_wmask,
    output logic            lsu_resp_valid,
    input  logic            lsu_resp_ready,
    output logic [DW-1:0]   lsu_rdata,
    output logic            lsu_err,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_wen,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    input  logic            mem_resp_valid,
    output logic            mem_resp_ready,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_err,
    output logic            busy
);

    arb_state_e      state_q, state_d;
    owner_e          owner_q, owner_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            wen_q, wen_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW/8-1:0] wmask_q, wmask_d;

    logic            grant_ifu, grant_lsu;
    logic            owner_rready, resp_hs, cnt_en, expired;
    logic            resp_v, resp_e;
    logic [DW-1:0]   resp_d;

    // owner_q doubles as last_owner: it is only rewritten on a grant.
    // Grants are gated by rst so every output reads 0 while reset is held.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (rst && (state_q == ST_IDLE)) begin
            if (ifu_req_valid && lsu_req_valid) begin
                grant_lsu = (owner_q == OWN_IFU);
                grant_ifu = (owner_q == OWN_LSU);
            end else begin
                grant_ifu = ifu_req_valid;
                grant_lsu = lsu_req_valid;
            end
        end
    end

    assign owner_rready = (owner_q == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;
    assign resp_hs      = (state_q == ST_RESP) && mem_resp_valid && owner_rready;
    assign cnt_en       = (state_q == ST_REQ) || (state_q == ST_RESP);

    ysyx_24110015_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (grant_ifu | grant_lsu),
        .en_i      (cnt_en),
        .expired_o (expired)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_lsu) begin
                    state_d = ST_REQ;
                    owner_d = OWN_LSU;
                    addr_d  = lsu_addr;
                    wen_d   = lsu_wen;
                    wdata_d = lsu_wdata;
                    wmask_d = lsu_wmask;
                end else if (grant_ifu) begin
                    state_d = ST_REQ;
                    owner_d = OWN_IFU;
                    addr_d  = ifu_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                end
            end
            // A handshake in the expiry cycle wins over the timeout.
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_d = ST_RESP;
                end else if (expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_RESP: begin
                if (resp_hs) begin
                    state_d = ST_IDLE;
                end else if (expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR: begin
                if (owner_rready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    always_comb begin
        resp_v = ((state_q == ST_RESP) && mem_resp_valid) || (state_q == ST_ERR);
        resp_e = ((state_q == ST_RESP) && mem_err) || (state_q == ST_ERR);
        resp_d = (state_q == ST_RESP) ? mem_rdata : '0;
    end

    assign ifu_req_ready  = grant_ifu;
    assign lsu_req_ready  = grant_lsu;
    assign ifu_resp_valid = (owner_q == OWN_IFU) && resp_v;
    assign ifu_err        = (owner_q == OWN_IFU) && resp_e;
    assign ifu_rdata      = (owner_q == OWN_IFU) ? resp_d : '0;
    assign lsu_resp_valid = (owner_q == OWN_LSU) && resp_v;
    assign lsu_err        = (owner_q == OWN_LSU) && resp_e;
    assign lsu_rdata      = (owner_q == OWN_LSU) ? resp_d : '0;

    assign mem_req_valid  = (state_q == ST_REQ);
    assign mem_resp_ready = (state_q == ST_RESP) && owner_rready;
    assign mem_addr       = addr_q;
    assign mem_wen        = wen_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ysyx_24110015_mem_arbiter.sv
// Bench for the memory arbiter: the bench plays both masters and the slave, and
// predicts grants, latched fields, responses and timeouts from the arbitration rules.
module tb_ysyx_24110015_mem_arbiter;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_req_valid = 1'b0, ifu_req_ready, ifu_resp_valid, ifu_resp_ready = 1'b0, ifu_err;
    logic [31:0] ifu_addr = '0, ifu_rdata;
    logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_wen = 1'b0, lsu_resp_valid, lsu_resp_ready = 1'b0, lsu_err;
    logic [31:0] lsu_addr = '0, lsu_wdata = '0, lsu_rdata;
    logic [3:0]  lsu_wmask = '0;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_wen, mem_resp_valid = 1'b0, mem_resp_ready, mem_err = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0]  mem_wmask;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    bit last  = 1'b0;  // model of last owner: 0 = IFU, 1 = LSU

    ysyx_24110015_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid),
        .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid),
        .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata), .mem_err(mem_err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 64'(|{ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_err, lsu_req_ready, lsu_resp_valid,
                       lsu_rdata, lsu_err, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
                       mem_resp_ready, busy}), 64'd0);
    endtask

    task automatic scramble_masters();
        ifu_req_valid  = 1'($urandom_range(0, 1));
        lsu_req_valid  = 1'($urandom_range(0, 1));
        ifu_addr       = $urandom;
        lsu_addr       = $urandom;
        lsu_wen        = 1'($urandom_range(0, 1));
        lsu_wdata      = $urandom;
        lsu_wmask      = 4'($urandom);
        ifu_resp_ready = 1'($urandom_range(0, 1));
        lsu_resp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        rst = 1'b0;
        #1;
        chk_all_zero("reset_outputs_zero");
        repeat (2) @(negedge clk);
        ifu_req_valid  = 1'b0;
        lsu_req_valid  = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        rst = 1'b1;
        last = 1'b0;
        #1;
        chk("post_reset_busy", busy, 0);
    endtask

    // One complete transaction. rq: REQ cycles the slave stalls before mem_req_ready;
    // rs: RESP cycles before mem_resp_valid; hold: ERR cycles the owner withholds resp_ready.
    task automatic txn(input bit iv, input bit lv, input int rq, input int rs, input int hold,
                       input logic [31:0] ia, input logic [31:0] la, input bit lw,
                       input logic [31:0] wd, input logic [3:0] wm,
                       input logic [31:0] rd, input bit re);
        bit          eo;
        bit          ok;
        int          used;
        logic [31:0] ea, ewd, cur_d;
        logic [3:0]  ewm;
        bit          ew, cur_v, cur_e;
        eo  = (iv && lv) ? ~last : lv;
        ea  = eo ? la : ia;
        ew  = eo ? lw : 1'b0;
        ewd = eo ? wd : 32'd0;
        ewm = eo ? wm : 4'd0;

        @(negedge clk);
        ifu_req_valid = iv; ifu_addr = ia;
        lsu_req_valid = lv; lsu_addr = la; lsu_wen = lw; lsu_wdata = wd; lsu_wmask = wm;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
        #1;
        chk("grant_ifu", ifu_req_ready, !eo);
        chk("grant_lsu", lsu_req_ready, eo);
        chk("idle_busy", busy, 0);
        last = eo;

        used = 0;
        ok   = 1'b0;
        while (1) begin
            @(negedge clk);
            scramble_masters();
            used++;
            mem_req_ready  = (used == rq + 1);
            mem_resp_valid = 1'b0;
            #1;
            chk("req_valid", mem_req_valid, 1);
            chk("req_addr", mem_addr, ea);
            chk("req_wen", mem_wen, ew);
            chk("req_wdata", mem_wdata, ewd);
            chk("req_wmask", mem_wmask, ewm);
            chk("req_no_grant", {ifu_req_ready, lsu_req_ready}, 0);
            chk("req_no_resp", {ifu_resp_valid, lsu_resp_valid, mem_resp_ready}, 0);
            chk("req_busy", busy, 1);
            if (used == rq + 1) begin
                ok = 1'b1;
                break;
            end
            if (used >= T) break;
        end

        if (ok) begin
            ok = 1'b0;
            for (int j = 1; j < 64; j++) begin
                @(negedge clk);
                scramble_masters();
                if (eo) lsu_resp_ready = 1'b1; else ifu_resp_ready = 1'b1;
                used++;
                cur_v = (j == rs + 1);
                cur_d = cur_v ? rd : $urandom;
                cur_e = cur_v ? re : 1'($urandom_range(0, 1));
                mem_req_ready  = 1'b0;
                mem_resp_valid = cur_v;
                mem_rdata      = cur_d;
                mem_err        = cur_e;
                #1;
                chk("resp_valid", eo ? lsu_resp_valid : ifu_resp_valid, cur_v);
                chk("resp_rdata", eo ? lsu_rdata : ifu_rdata, cur_d);
                chk("resp_err", eo ? lsu_err : ifu_err, cur_e);
                chk("resp_other_quiet", eo ? ifu_resp_valid : lsu_resp_valid, 0);
                chk("resp_mem_ready", mem_resp_ready, 1);
                chk("resp_no_req", mem_req_valid, 0);
                chk("resp_no_grant", {ifu_req_ready, lsu_req_ready}, 0);
                if (cur_v) begin
                    ok = 1'b1;
                    break;
                end
                if (used >= T) break;
            end
        end

        if (!ok) begin
            for (int h = 0; h <= hold; h++) begin
                @(negedge clk);
                scramble_masters();
                if (eo) lsu_resp_ready = (h == hold); else ifu_resp_ready = (h == hold);
                mem_req_ready  = 1'b0;
                mem_resp_valid = 1'b0;
                mem_rdata      = $urandom;
                mem_err        = 1'b0;
                #1;
                chk("err_valid", eo ? lsu_resp_valid : ifu_resp_valid, 1);
                chk("err_flag", eo ? lsu_err : ifu_err, 1);
                chk("err_rdata", eo ? lsu_rdata : ifu_rdata, 0);
                chk("err_other_quiet", eo ? ifu_resp_valid : lsu_resp_valid, 0);
                chk("err_mem_quiet", {mem_req_valid, mem_resp_ready}, 0);
                chk("err_busy", busy, 1);
            end
        end

        @(negedge clk);
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_err = 1'b0;
        #1;
        chk("done_idle", busy, 0);
        chk("done_no_req", mem_req_valid, 0);
    endtask

    initial begin
        bit iv, lv;
        do_reset();

        // IFU-only fetch, minimum latency
        txn(1, 0, 0, 0, 0, 32'h8000_0000, 32'h0, 0, 32'h0, 4'h0, 32'h0000_0413, 0);
        // LSU store with a stalling slave
        txn(0, 1, 3, 1, 0, 32'h0, 32'h8000_0100, 1, 32'hDEAD_BEEF, 4'hF, 32'h0, 0);

        // Conflicts straight after reset: LSU, IFU, LSU, IFU
        do_reset();
        for (int i = 0; i < 4; i++) begin
            txn(1, 1, 0, 0, 0, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
                $urandom, 0);
        end

        // Timeouts: hung in REQ, hung in RESP, and both sides of the boundary
        txn(1, 0, 20, 0, 2, $urandom, 32'h0, 0, 32'h0, 4'h0, $urandom, 0);
        txn(0, 1, 0, 20, 1, 32'h0, $urandom, 0, 32'h0, 4'h0, $urandom, 0);
        txn(1, 0, 3, 3, 0, $urandom, 32'h0, 0, 32'h0, 4'h0, 32'h1234_5678, 1);
        txn(1, 0, 3, 4, 0, $urandom, 32'h0, 0, 32'h0, 4'h0, 32'h1234_5678, 0);
        txn(0, 1, 7, 0, 0, 32'h0, $urandom, 1, $urandom, 4'h3, 32'hCAFE_F00D, 0);
        txn(0, 1, 7, 1, 0, 32'h0, $urandom, 0, $urandom, 4'h3, 32'hCAFE_F00D, 0);
        txn(1, 1, 0, 0, 0, $urandom, $urandom, 1, $urandom, 4'($urandom), $urandom, 0);

        // Reset in RESP with a response pending
        @(negedge clk);
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b0; ifu_addr = 32'h8000_0040;
        #1;
        chk("rstresp_grant", ifu_req_ready, 1);
        @(negedge clk);
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'hA5A5_A5A5; ifu_resp_ready = 1'b0;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        #1;
        chk("rstresp_pending", ifu_resp_valid, 1);
        rst = 1'b0;
        #1;
        chk_all_zero("rstresp_outputs_zero");
        @(negedge clk);
        mem_resp_valid = 1'b0; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        rst = 1'b1;
        last = 1'b0;
        #1;
        chk("rstresp_idle", busy, 0);
        txn(1, 1, 1, 1, 0, $urandom, $urandom, 0, $urandom, 4'($urandom), $urandom, 0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            iv = 1'($urandom_range(0, 1));
            lv = iv ? 1'($urandom_range(0, 1)) : 1'b1;
            txn(iv, lv, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 2),
                $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
                $urandom, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
